// File: rtl/tb_pkg.sv
// tb_pkg: shared response payload and default memory sizes
// for the OBI memory model.
package tb_pkg;

  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned IMEM_SIZE  = 32'h0001_0000;
  localparam int unsigned DMEM_SIZE  = 32'h0001_0000;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] rdata;
    logic                  err;
  } mem_rsp_t;

endpackage

// File: rtl/mem_rsp_pipe.sv
// mem_rsp_pipe: fixed-latency valid/payload delay line.
// Empty slots carry a zero payload so the tail never shows stale data.
module mem_rsp_pipe
  import tb_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     valid_i,
  input  mem_rsp_t rsp_i,
  output logic     valid_o,
  output mem_rsp_t rsp_o,
  output logic     tail_load_o
);

  logic [LAT-1:0] valid_q;
  logic [LAT-1:0] valid_d;
  mem_rsp_t       rsp_q [LAT];
  mem_rsp_t       rsp_d [LAT];

  always_comb begin
    valid_d[0] = valid_i;
    rsp_d[0]   = valid_i ? rsp_i : '0;
    for (int i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      rsp_d[i]   = rsp_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        rsp_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rsp_q   <= rsp_d;
    end
  end

  assign valid_o     = valid_q[LAT-1];
  assign rsp_o       = rsp_q[LAT-1];
  // A response leaves the outstanding set when it enters the tail slot.
  assign tail_load_o = valid_d[LAT-1];

endmodule

// File: rtl/obi_mem_model.sv
// obi_mem_model: behavioural OBI slave memory, fixed response latency.
// Define MEM_MODEL_ERR_EN to flag out-of-range addresses on err_o.
module obi_mem_model
  import tb_pkg::*;
#(
  parameter int unsigned MEM_SIZE        = DMEM_SIZE,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned RSP_LAT         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned GNT_STALL_N     = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o
`ifdef MEM_MODEL_ERR_EN
  ,
  output logic                err_o
`endif
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned BW    = $clog2(NB);
  localparam int unsigned AW    = $clog2(MEM_SIZE);
  localparam int unsigned IW    = AW - BW;
  localparam int unsigned DEPTH = MEM_SIZE / NB;
  localparam int unsigned CW    = $clog2(MAX_OUTSTANDING + 2);
  localparam int unsigned SW    =
    (GNT_STALL_N > 1) ? $clog2(GNT_STALL_N) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IW-1:0] idx;
  logic          oob;
  logic          stall_sel;
  logic          wr_en;
  logic          rsp_v;
  logic          tail_load;
  mem_rsp_t      rsp_in;
  mem_rsp_t      rsp_out;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [SW-1:0] stall_q;
  logic [SW-1:0] stall_d;

  // Truncating the shifted address wraps modulo MEM_SIZE.
  assign idx = IW'(addr_i >> BW);

`ifdef MEM_MODEL_ERR_EN
  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_SIZE);
  assign oob = {1'b0, addr_i} >= MEM_LIM;
`else
  assign oob = 1'b0;
`endif

  assign stall_sel = (GNT_STALL_N != 0) &&
                     (stall_q == SW'(GNT_STALL_N - 1));

  assign gnt_o = req_i && !rst_i && !stall_sel &&
                 (cnt_q < CW'(MAX_OUTSTANDING));

  assign wr_en = gnt_o && we_i && !oob;

  always_comb begin
    rsp_in     = '0;
    rsp_in.err = gnt_o && oob;
    if (gnt_o && !we_i && !oob) begin
      rsp_in.rdata = MAX_DATA_W'(mem[idx]);
    end
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(gnt_o) - CW'(tail_load);
    stall_d = stall_q;
    if (req_i && GNT_STALL_N != 0) begin
      stall_d = stall_sel ? '0 : stall_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Storage is deliberately not reset; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_en && be_i[b]) begin
        mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  mem_rsp_pipe #(
    .LAT (RSP_LAT)
  ) u_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (gnt_o),
    .rsp_i       (rsp_in),
    .valid_o     (rsp_v),
    .rsp_o       (rsp_out),
    .tail_load_o (tail_load)
  );

  assign rvalid_o = rsp_v && !rst_i;
  assign rdata_o  = (rvalid_o && !rsp_out.err) ?
                    DATA_W'(rsp_out.rdata) : '0;

`ifdef MEM_MODEL_ERR_EN
  assign err_o = rvalid_o && rsp_out.err;
`endif

endmodule

// File: tb/tb_obi_mem_model.sv
// tb_obi_mem_model: randomized and directed checks of obi_mem_model
// across four latency/outstanding/stall configurations.
module tb_obi_mem_model;
  import tb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_a, req_b, req_c, req_d;
  logic        gnt_a, gnt_b, gnt_c, gnt_d;
  logic        rv_a, rv_b, rv_c, rv_d;
  logic [31:0] rd_a, rd_b, rd_c, rd_d;
  logic        er_a, er_b, er_c, er_d;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        er;
  } obs_t;

  // Byte-level reference image of u_a (4 KiB) and its pending response.
  logic [7:0]  mdl [4096];
  logic        pend_v;
  logic [31:0] pend_d;
  logic        pend_e;
  logic [31:0] wd_mem [8];

  obi_mem_model #(
    .MEM_SIZE(4096), .DATA_W(32), .ADDR_W(32),
    .RSP_LAT(1), .MAX_OUTSTANDING(1), .GNT_STALL_N(0)
  ) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we),
    .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt_a), .rvalid_o(rv_a), .rdata_o(rd_a)
`ifdef MEM_MODEL_ERR_EN
    , .err_o(er_a)
`endif
  );

  obi_mem_model #(
    .MEM_SIZE(DMEM_SIZE), .DATA_W(32), .ADDR_W(32),
    .RSP_LAT(3), .MAX_OUTSTANDING(2), .GNT_STALL_N(0)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we),
    .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt_b), .rvalid_o(rv_b), .rdata_o(rd_b)
`ifdef MEM_MODEL_ERR_EN
    , .err_o(er_b)
`endif
  );

  obi_mem_model #(
    .MEM_SIZE(4096), .DATA_W(32), .ADDR_W(32),
    .RSP_LAT(8), .MAX_OUTSTANDING(8), .GNT_STALL_N(3)
  ) u_c (
    .clk_i(clk), .rst_i(rst), .req_i(req_c), .we_i(we),
    .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt_c), .rvalid_o(rv_c), .rdata_o(rd_c)
`ifdef MEM_MODEL_ERR_EN
    , .err_o(er_c)
`endif
  );

  obi_mem_model #(
    .MEM_SIZE(IMEM_SIZE), .DATA_W(32), .ADDR_W(32),
    .RSP_LAT(4), .MAX_OUTSTANDING(4), .GNT_STALL_N(0)
  ) u_d (
    .clk_i(clk), .rst_i(rst), .req_i(req_d), .we_i(we),
    .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt_d), .rvalid_o(rv_d), .rdata_o(rd_d)
`ifdef MEM_MODEL_ERR_EN
    , .err_o(er_d)
`endif
  );

`ifndef MEM_MODEL_ERR_EN
  assign er_a = 1'b0;
  assign er_b = 1'b0;
  assign er_c = 1'b0;
  assign er_d = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One u_a cycle: drive, sample, and advance the reference model.
  task automatic a_cycle(input logic rq, input logic w,
                         input logic [3:0] b, input logic [31:0] ad,
                         input logic [31:0] wd,
                         output obs_t ob, output obs_t ex);
    logic [31:0] base;
    logic        bad;
    req_a = rq; we = w; be = b; addr = ad; wdata = wd;
    #1;
    ob = '{gnt: gnt_a, rv: rv_a, rd: rd_a, er: er_a};
    ex = '{gnt: rq, rv: pend_v, rd: pend_d, er: pend_e};
`ifdef MEM_MODEL_ERR_EN
    bad = ad >= 32'd4096;
`else
    bad = 1'b0;
`endif
    base   = (ad % 32'd4096) & ~32'd3;
    pend_v = rq;
    pend_d = '0;
    pend_e = rq && bad;
    if (rq && !bad) begin
      if (w) begin
        for (int k = 0; k < 4; k++) begin
          if (b[k]) mdl[base+k] = wd[8*k +: 8];
        end
      end else begin
        pend_d = {mdl[base+3], mdl[base+2], mdl[base+1], mdl[base]};
      end
    end
    @(posedge clk);
    #1;
    req_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {req_a, req_b, req_c, req_d} = 4'hF;
    we = 1'b1; be = 4'hF; addr = '0; wdata = 32'h5A5A_5A5A;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if ({gnt_a, gnt_b, gnt_c, gnt_d} !== 4'b0) begin
        n_bad++;
        $display("FAIL reset_gnt c%0d: got %b want 0000", c,
                 {gnt_a, gnt_b, gnt_c, gnt_d});
      end
      n_cmp++;
      if ({rv_a, rv_b, rv_c, rv_d, er_a, er_b, er_c, er_d} !== 8'b0)
      begin
        n_bad++;
        $display("FAIL reset_rv_err c%0d: got %b want 0", c,
                 {rv_a, rv_b, rv_c, rv_d, er_a, er_b, er_c, er_d});
      end
      n_cmp++;
      if ({rd_a, rd_b, rd_c, rd_d} !== 128'b0) begin
        n_bad++;
        $display("FAIL reset_rdata c%0d: got %h want 0", c,
                 {rd_a, rd_b, rd_c, rd_d});
      end
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    {req_a, req_b, req_c, req_d} = 4'h0;
    pend_v = 1'b0; pend_d = '0; pend_e = 1'b0;
  endtask

  task automatic test_single_word();
    obs_t ob, ex;
    a_cycle(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, ob, ex);
    a_cycle(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, ob, ex);
    n_cmp++;
    if (ob !== ex) begin
      n_bad++;
      $display("FAIL single_wr_rsp: got %h want %h", ob, ex);
    end
    a_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ob, ex);
    n_cmp++;
    if (ob.rv !== 1'b1 || ob.rd !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL single_rd: got rv=%b rd=%h want rv=1 rd=deadbeef",
               ob.rv, ob.rd);
    end
    a_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ob, ex);
    n_cmp++;
    if (ob.rv !== 1'b0 || ob.rd !== 32'h0) begin
      n_bad++;
      $display("FAIL single_one_shot: got rv=%b rd=%h want 0 0",
               ob.rv, ob.rd);
    end
  endtask

  task automatic test_byte_enable();
    obs_t ob, ex;
    a_cycle(1'b1, 1'b1, 4'hF, 32'h20, 32'h1122_3344, ob, ex);
    a_cycle(1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000_AA00, ob, ex);
    a_cycle(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, ob, ex);
    a_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ob, ex);
    n_cmp++;
    if (ob.rv !== 1'b1 || ob.rd !== 32'h1122_AA44 || ob !== ex) begin
      n_bad++;
      $display("FAIL byte_enable: got %h want rd=1122aa44 (%h)", ob, ex);
    end
  endtask

  task automatic test_oob();
    obs_t ob, ex;
    logic [31:0] want;
    a_cycle(1'b1, 1'b1, 4'hF, 32'h0, 32'hCAFE_F00D, ob, ex);
    a_cycle(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0, ob, ex);
    a_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ob, ex);
    n_cmp++;
`ifdef MEM_MODEL_ERR_EN
    if (ob.rv !== 1'b1 || ob.er !== 1'b1 || ob.rd !== 32'h0) begin
`else
    if (ob.rv !== 1'b1 || ob.er !== 1'b0 || ob.rd !== 32'hCAFE_F00D) begin
`endif
      n_bad++;
      $display("FAIL oob_read: got %h want %h", ob, ex);
    end
    a_cycle(1'b1, 1'b1, 4'hF, 32'h1000, 32'h1357_9BDF, ob, ex);
    a_cycle(1'b1, 1'b0, 4'hF, 32'h0, 32'h0, ob, ex);
    a_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ob, ex);
`ifdef MEM_MODEL_ERR_EN
    want = 32'hCAFE_F00D;
`else
    want = 32'h1357_9BDF;
`endif
    n_cmp++;
    if (ob.rd !== want || ob !== ex) begin
      n_bad++;
      $display("FAIL oob_write: got rd=%h want %h", ob.rd, want);
    end
  endtask

  task automatic test_random();
    obs_t ob, ex;
    logic [31:0] ad;
    for (int i = 0; i < 64; i++) begin
      a_cycle(1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom, ob, ex);
      n_cmp++;
      if (ob !== ex) begin
        n_bad++;
        $display("FAIL rand_init %0d: got %h want %h", i, ob, ex);
      end
    end
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) ad = 32'h1000 + ($urandom % 256);
      else ad = $urandom % 256;
      a_cycle($urandom_range(0, 3) != 0, 1'($urandom),
              4'($urandom), ad, $urandom, ob, ex);
      n_cmp++;
      if (ob !== ex) begin
        n_bad++;
        $display("FAIL rand %0d: got %h want %h", i, ob, ex);
      end
    end
    a_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ob, ex);
    n_cmp++;
    if (ob !== ex) begin
      n_bad++;
      $display("FAIL rand_drain: got %h want %h", ob, ex);
    end
  endtask

  // u_b: latency 3, at most 2 in flight; a response frees its slot
  // in the cycle it is presented.
  task automatic test_outstanding();
    int   gq[$];
    int   inflight;
    logic eg, erv;
    logic [3:0] pat;
    pat = '0;
    for (int t = 0; t < 12; t++) begin
      req_b = (t < 6); we = 1'b1; be = 4'hF;
      addr = 32'(t * 4); wdata = $urandom;
      #1;
      inflight = 0;
      erv = 1'b0;
      foreach (gq[j]) begin
        if (gq[j] < t && t < gq[j] + 3) inflight++;
        if (gq[j] + 3 == t) erv = 1'b1;
      end
      eg = req_b && (inflight < 2);
      if (t < 4) pat[3-t] = gnt_b;
      n_cmp++;
      if (gnt_b !== eg || rv_b !== erv || rd_b !== 32'h0) begin
        n_bad++;
        $display("FAIL outstanding t%0d: got g=%b v=%b d=%h want %b %b 0",
                 t, gnt_b, rv_b, rd_b, eg, erv);
      end
      if (eg) gq.push_back(t);
      tick();
    end
    req_b = 1'b0;
    n_cmp++;
    if (pat !== 4'b1101) begin
      n_bad++;
      $display("FAIL outstanding_pat: got %b want 1101", pat);
    end
  endtask

  task automatic test_stall();
    int   k;
    logic eg;
    logic [5:0] pat;
    k = 0;
    pat = '0;
    for (int t = 0; t < 8; t++) begin
      req_c = (t < 6); we = 1'b1; be = 4'hF;
      addr = 32'(t * 4); wdata = $urandom;
      #1;
      eg = req_c && (k % 3 != 2);
      if (req_c) k++;
      if (t < 6) pat[5-t] = gnt_c;
      n_cmp++;
      if (gnt_c !== eg || rd_c !== 32'h0) begin
        n_bad++;
        $display("FAIL stall t%0d: got g=%b d=%h want %b 0",
                 t, gnt_c, rd_c, eg);
      end
      tick();
    end
    req_c = 1'b0;
    n_cmp++;
    if (pat !== 6'b110110) begin
      n_bad++;
      $display("FAIL stall_pat: got %b want 110110", pat);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_rv [32];
    logic [31:0] exp_rd [32];
    for (int i = 0; i < 32; i++) begin
      exp_rv[i] = 1'b0;
      exp_rd[i] = '0;
    end
    for (int i = 0; i < 8; i++) wd_mem[i] = $urandom;
    for (int t = 0; t < 21; t++) begin
      req_d = (t < 16); we = (t < 8); be = 4'hF;
      addr = 32'((t % 8) * 4); wdata = wd_mem[t % 8];
      #1;
      n_cmp++;
      if (gnt_d !== req_d || rv_d !== exp_rv[t] || rd_d !== exp_rd[t])
      begin
        n_bad++;
        $display("FAIL b2b t%0d: got g=%b v=%b d=%h want %b %b %h",
                 t, gnt_d, rv_d, rd_d, req_d, exp_rv[t], exp_rd[t]);
      end
      if (req_d) begin
        exp_rv[t+4] = 1'b1;
        exp_rd[t+4] = we ? 32'h0 : wd_mem[t % 8];
      end
      tick();
    end
    req_d = 1'b0;
  endtask

  task automatic test_reset_midflight();
    for (int t = 0; t < 2; t++) begin
      req_d = 1'b1; we = 1'b0; addr = 32'(t * 4);
      #1;
      n_cmp++;
      if (gnt_d !== 1'b1) begin
        n_bad++;
        $display("FAIL midrst_gnt t%0d: got %b want 1", t, gnt_d);
      end
      tick();
    end
    rst = 1'b1; req_d = 1'b1; we = 1'b1; be = 4'hF;
    addr = 32'h0; wdata = 32'hBADB_AD00;
    #1;
    n_cmp++;
    if (gnt_d !== 1'b0 || rv_d !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_during: got g=%b v=%b want 0 0", gnt_d, rv_d);
    end
    tick();
    rst = 1'b0; req_d = 1'b0;
    for (int t = 0; t < 8; t++) begin
      #1;
      n_cmp++;
      if (rv_d !== 1'b0 || rd_d !== 32'h0) begin
        n_bad++;
        $display("FAIL midrst_flush t%0d: got v=%b d=%h want 0 0",
                 t, rv_d, rd_d);
      end
      tick();
    end
    req_d = 1'b1; we = 1'b0; addr = 32'h0;
    tick();
    req_d = 1'b0;
    for (int t = 1; t < 4; t++) tick();
    n_cmp++;
    if (rv_d !== 1'b1 || rd_d !== wd_mem[0]) begin
      n_bad++;
      $display("FAIL midrst_keep: got v=%b d=%h want 1 %h",
               rv_d, rd_d, wd_mem[0]);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    {req_a, req_b, req_c, req_d} = 4'h0;
    we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    pend_v = 1'b0; pend_d = '0; pend_e = 1'b0;
    test_reset();
    test_single_word();
    test_byte_enable();
    test_oob();
    test_random();
    test_outstanding();
    test_stall();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
